// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, branch redirect,
// fetch wait states and multi-cycle MDU occupancy of EX, plus a stall-cycle counter.
module pipeline_hazard_ctrl #(
   parameter int MDU_LAT = 4,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       id_rs1_i,
   input  logic [4:0]       id_rs2_i,
   input  logic             id_uses_rs1_i,
   input  logic             id_uses_rs2_i,
   input  logic             ex_mem_read_i,
   input  logic [4:0]       ex_rd_i,
   input  logic             ex_branch_taken_i,
   input  logic             ex_mdu_start_i,
   input  logic             imem_ready_i,
   input  logic             clr_cnt_i,
   output logic             pc_stall_o,
   output logic             if_id_stall_o,
   output logic             if_id_flush_o,
   output logic             id_ex_stall_o,
   output logic             id_ex_flush_o,
   output logic             ex_mem_flush_o,
   output logic             mdu_busy_o,
   output logic [CNT_W-1:0] stall_cycles_o
);

   localparam int CW = (MDU_LAT > 2) ? $clog2(MDU_LAT) : 1;

   typedef enum logic {RUN, BUSY} state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic          load_use;
   logic          mdu_go;

   always_comb begin
      load_use = ex_mem_read_i && (ex_rd_i != 5'd0) &&
                 ((id_uses_rs1_i && (id_rs1_i == ex_rd_i)) ||
                  (id_uses_rs2_i && (id_rs2_i == ex_rd_i)));
      mdu_go   = (MDU_LAT >= 2) && ex_mdu_start_i && !ex_branch_taken_i;
   end

   // Priority resolution; everything is forced low while reset is held.
   always_comb begin
      pc_stall_o     = 1'b0;
      if_id_stall_o  = 1'b0;
      if_id_flush_o  = 1'b0;
      id_ex_stall_o  = 1'b0;
      id_ex_flush_o  = 1'b0;
      ex_mem_flush_o = 1'b0;
      if (!rst) begin
         if (state == BUSY) begin
            if (cnt > CW'(1)) begin
               pc_stall_o     = 1'b1;
               if_id_stall_o  = 1'b1;
               id_ex_stall_o  = 1'b1;
               ex_mem_flush_o = 1'b1;
            end
         end else if (ex_branch_taken_i) begin
            if_id_flush_o = 1'b1;
            id_ex_flush_o = 1'b1;
         end else if (mdu_go) begin
            pc_stall_o     = 1'b1;
            if_id_stall_o  = 1'b1;
            id_ex_stall_o  = 1'b1;
            ex_mem_flush_o = 1'b1;
         end else if (load_use) begin
            pc_stall_o    = 1'b1;
            if_id_stall_o = 1'b1;
            id_ex_flush_o = 1'b1;
         end else if (!imem_ready_i) begin
            pc_stall_o    = 1'b1;
            if_id_flush_o = 1'b1;
         end
      end
   end

   // cnt counts the remaining BUSY cycles; the last one releases the pipeline.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= RUN;
         cnt   <= '0;
      end else begin
         case (state)
            RUN: begin
               if (mdu_go) begin
                  state <= BUSY;
                  cnt   <= CW'(MDU_LAT - 1);
               end
            end
            BUSY: begin
               if (cnt > CW'(1)) begin
                  cnt <= cnt - CW'(1);
               end else begin
                  state <= RUN;
                  cnt   <= '0;
               end
            end
            default: state <= RUN;
         endcase
      end
   end

   assign mdu_busy_o = (state == BUSY);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cycles_o <= '0;
      end else if (clr_cnt_i) begin
         stall_cycles_o <= '0;
      end else if (pc_stall_o && (stall_cycles_o != '1)) begin
         stall_cycles_o <= stall_cycles_o + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: a cycle model pushes expected
// outputs into a scoreboard queue as stimulus is driven, popped when sampled.
module tb_pipeline_hazard_ctrl;

   localparam int MDU_LAT = 4;
   localparam int CNT_W   = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic [4:0]       id_rs1, id_rs2, ex_rd;
   logic             id_uses_rs1, id_uses_rs2, ex_mem_read;
   logic             ex_branch_taken, ex_mdu_start, imem_ready, clr_cnt;
   logic             pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush;
   logic             ex_mem_flush, mdu_busy;
   logic [CNT_W-1:0] stall_cycles;

   typedef struct packed {
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic       u1;
      logic       u2;
      logic       mr;
      logic [4:0] rd;
      logic       br;
      logic       mdu;
      logic       imem;
      logic       clr;
   } stim_t;

   typedef struct packed {
      logic [6:0] ctl;
      logic [3:0] cnt;
   } exp_t;

   localparam logic [6:0] C_IDLE   = 7'b0000000;
   localparam logic [6:0] C_BRANCH = 7'b0010100;
   localparam logic [6:0] C_MDU    = 7'b1101010;
   localparam logic [6:0] C_BUSYST = 7'b1101011;
   localparam logic [6:0] C_BUSYND = 7'b0000001;
   localparam logic [6:0] C_LDUSE  = 7'b1100100;
   localparam logic [6:0] C_IMEM   = 7'b1010000;

   exp_t sbQ[$];
   int   compared = 0;
   int   mismatched = 0;
   int   mBusy = 0;
   int   mCnt = 0;

   always #5 clk = ~clk;

   pipeline_hazard_ctrl #(.MDU_LAT(MDU_LAT), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
      .id_uses_rs1_i(id_uses_rs1), .id_uses_rs2_i(id_uses_rs2),
      .ex_mem_read_i(ex_mem_read), .ex_rd_i(ex_rd),
      .ex_branch_taken_i(ex_branch_taken), .ex_mdu_start_i(ex_mdu_start),
      .imem_ready_i(imem_ready), .clr_cnt_i(clr_cnt),
      .pc_stall_o(pc_stall), .if_id_stall_o(if_id_stall), .if_id_flush_o(if_id_flush),
      .id_ex_stall_o(id_ex_stall), .id_ex_flush_o(id_ex_flush),
      .ex_mem_flush_o(ex_mem_flush), .mdu_busy_o(mdu_busy),
      .stall_cycles_o(stall_cycles)
   );

   function automatic stim_t idle();
      stim_t s;
      s      = '0;
      s.imem = 1'b1;
      return s;
   endfunction

   // Reference behaviour of one cycle, derived from the current model state.
   function automatic logic [6:0] modelCtl(stim_t s);
      logic lu;
      lu = s.mr && (s.rd != 5'd0) &&
           ((s.u1 && s.rs1 == s.rd) || (s.u2 && s.rs2 == s.rd));
      if (mBusy > 1)     return C_BUSYST;
      if (mBusy == 1)    return C_BUSYND;
      if (s.br)          return C_BRANCH;
      if (s.mdu)         return C_MDU;
      if (lu)            return C_LDUSE;
      if (!s.imem)       return C_IMEM;
      return C_IDLE;
   endfunction

   task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      compared++;
      if (obs !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic compareNext(input string tag);
      exp_t e;
      if (sbQ.size() == 0) begin
         checkOutput({tag, "_sb_empty"}, 16'd1, 16'd0);
      end else begin
         e = sbQ.pop_front();
         checkOutput({tag, "_ctl"},
                     {9'd0, pc_stall, if_id_stall, if_id_flush, id_ex_stall,
                      id_ex_flush, ex_mem_flush, mdu_busy}, {9'd0, e.ctl});
         checkOutput({tag, "_cnt"}, {12'd0, stall_cycles}, {12'd0, e.cnt});
      end
   endtask

   task automatic applyStimulus(input stim_t s, input string tag);
      exp_t e;
      @(negedge clk);
      id_rs1 = s.rs1;  id_rs2 = s.rs2;
      id_uses_rs1 = s.u1;  id_uses_rs2 = s.u2;
      ex_mem_read = s.mr;  ex_rd = s.rd;
      ex_branch_taken = s.br;  ex_mdu_start = s.mdu;
      imem_ready = s.imem;  clr_cnt = s.clr;
      e.ctl = modelCtl(s);
      e.cnt = 4'(mCnt);
      sbQ.push_back(e);
      #1;
      compareNext(tag);
      if (mBusy > 0)          mBusy--;
      else if (!s.br && s.mdu) mBusy = MDU_LAT - 1;
      if (s.clr)                     mCnt = 0;
      else if (e.ctl[6] && mCnt < 15) mCnt++;
   endtask

   task automatic driveIdle();
      stim_t s;
      s = idle();
      id_rs1 = s.rs1;  id_rs2 = s.rs2;
      id_uses_rs1 = s.u1;  id_uses_rs2 = s.u2;
      ex_mem_read = s.mr;  ex_rd = s.rd;
      ex_branch_taken = s.br;  ex_mdu_start = s.mdu;
      imem_ready = s.imem;  clr_cnt = s.clr;
   endtask

   // Reset asserted in the middle of a cycle, held across one edge, released idle.
   task automatic resetPulse(input string tag);
      @(negedge clk);
      rst = 1'b1;
      sbQ.push_back('0);
      #1;
      compareNext({tag, "_assert"});
      mBusy = 0;
      mCnt  = 0;
      @(posedge clk);
      #1;
      sbQ.push_back('0);
      compareNext({tag, "_hold"});
      @(negedge clk);
      driveIdle();
      rst = 1'b0;
   endtask

   initial begin
      stim_t s;
      rst = 1'b1;
      driveIdle();
      @(negedge clk);
      sbQ.push_back('0);
      #1;
      compareNext("reset");
      @(negedge clk);
      rst = 1'b0;

      // Load-use via rs1, with x0, via rs2, and with an unused operand
      s = idle(); s.mr = 1; s.rd = 5; s.rs1 = 5; s.u1 = 1;
      applyStimulus(s, "lu_rs1");
      s.rd = 0; s.rs1 = 0;
      applyStimulus(s, "lu_x0");
      s = idle(); s.mr = 1; s.rd = 7; s.rs2 = 7; s.u2 = 1;
      applyStimulus(s, "lu_rs2");
      s.u2 = 0;
      applyStimulus(s, "lu_unused");

      s = idle(); s.mr = 1; s.rd = 9; s.rs1 = 9; s.u1 = 1; s.br = 1;
      applyStimulus(s, "branch_lu");

      // MDU op held four cycles, then a load-use shows the FSM is back in RUN
      s = idle(); s.mdu = 1;
      for (int i = 0; i < MDU_LAT; i++) applyStimulus(s, "mdu");
      s = idle(); s.mr = 1; s.rd = 3; s.rs1 = 3; s.u1 = 1;
      applyStimulus(s, "mdu_after");

      s = idle(); s.imem = 0;
      applyStimulus(s, "imem0");
      applyStimulus(s, "imem1");
      s.mr = 1; s.rd = 4; s.rs2 = 4; s.u2 = 1;
      applyStimulus(s, "imem_lu");

      s = idle(); s.br = 1; s.mdu = 1;
      applyStimulus(s, "br_mdu");
      applyStimulus(idle(), "br_mdu_next");

      s = idle(); s.mdu = 1;
      applyStimulus(s, "rstmdu0");
      applyStimulus(s, "rstmdu1");
      resetPulse("rst_busy");
      applyStimulus(idle(), "post_rst");

      s = idle(); s.imem = 0;
      for (int i = 0; i < 20; i++) applyStimulus(s, "sat");
      applyStimulus(idle(), "sat_hold");
      s.clr = 1;
      applyStimulus(s, "clr_stall");
      applyStimulus(idle(), "clr_after");

      for (int i = 0; i < 60; i++) begin
         s.rs1  = 5'($urandom_range(0, 3));
         s.rs2  = 5'($urandom_range(0, 3));
         s.rd   = 5'($urandom_range(0, 3));
         s.u1   = 1'($urandom);
         s.u2   = 1'($urandom);
         s.mr   = 1'($urandom);
         s.br   = ($urandom_range(0, 7) == 0);
         s.mdu  = ($urandom_range(0, 7) == 0);
         s.imem = ($urandom_range(0, 3) != 0);
         s.clr  = ($urandom_range(0, 15) == 0);
         applyStimulus(s, "rand");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
